// File: rtl/keypad_sb_ctrl.sv
// 4x4 matrix keypad controller on the system bus: column scan, row synchronizer,
// frame debounce, press latch with interrupt, and a small register window.
module keypad_sb_ctrl #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] write_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  output logic [3:0]  kp_col_o,
  input  logic [3:0]  kp_row_i
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  localparam logic [31:0] ADDR_KEY    = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] ADDR_MATRIX = 32'h0000_0008;
  localparam logic [31:0] ADDR_RESET  = 32'h0000_0024;

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       kp_col_q, kp_col_d;
  logic [15:0]      frame_q, frame_d;
  logic [15:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      matrix_q, matrix_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        rd_c, wr_c, key_rd_c, soft_rst_c;
  logic        tick_c, frame_done_c, accept_c, event_c;
  logic [15:0] frame_full_c, rising_c;
  logic [3:0]  key_code_c;

  // Upper write-data bits carry no meaning for this block.
  logic unused_wdata;
  assign unused_wdata = ^write_data_i[31:1];

  // Bus decode and scan timing.
  always_comb begin
    rd_c         = req_i & ~write_enable_i;
    wr_c         = req_i & write_enable_i;
    key_rd_c     = rd_c & (addr_i == ADDR_KEY);
    soft_rst_c   = wr_c & (addr_i == ADDR_RESET) & write_data_i[0];
    tick_c       = (div_q == DIV_LAST);
    frame_done_c = tick_c & (col_q == 2'd3);
  end

  // Merge the current column's rows into the frame being assembled.
  always_comb begin
    frame_full_c = frame_q;
    for (int r = 0; r < 4; r++) begin
      frame_full_c[{2'(r), col_q}] = ~row_sync_q[r];
    end
  end

  // Next-state logic for scanner, debounce, press latch and bus.
  always_comb begin
    row_meta_d = kp_row_i;
    row_sync_d = row_meta_q;
    div_d      = tick_c ? '0 : div_q + DIV_W'(1);
    col_d      = tick_c ? col_q + 2'd1 : col_q;
    kp_col_d   = ~(4'b0001 << col_d);
    frame_d    = tick_c ? frame_full_c : frame_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    matrix_d   = matrix_q;
    accept_c   = 1'b0;

    if (frame_done_c) begin
      prev_d = frame_full_c;
      if (frame_full_c == prev_q) begin
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
      if (cnt_d == CNT_LAST) begin
        accept_c = 1'b1;
        matrix_d = frame_full_c;
      end
    end

    rising_c = accept_c ? (frame_full_c & ~matrix_q) : 16'h0000;
    event_c  = |rising_c;

    // Lowest pressed index wins when several keys rise together.
    key_code_c = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rising_c[i]) key_code_c = 4'(i);
    end

    key_d     = event_c ? key_code_c : key_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    irq_d     = irq_q;

    if (key_rd_c) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      irq_d     = 1'b0;
    end
    if (interrupt_return_i) irq_d = 1'b0;
    // A press coinciding with a KEY read still counts as overrunning the read value.
    if (event_c) begin
      valid_d = 1'b1;
      irq_d   = 1'b1;
      if (valid_q | key_rd_c) overrun_d = 1'b1;
    end

    rdata_d = rdata_q;
    if (rd_c) begin
      case (addr_i)
        ADDR_KEY:    rdata_d = {28'h0, key_q};
        ADDR_STATUS: rdata_d = {30'h0, overrun_q, valid_q};
        ADDR_MATRIX: rdata_d = {16'h0, matrix_q};
        default:     rdata_d = 32'h0;
      endcase
    end
  end

  // State registers; hard and soft reset behave identically.
  always_ff @(posedge clk_i) begin
    if (rst | soft_rst_c) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_q      <= 2'd0;
      kp_col_q   <= 4'b1110;
      frame_q    <= 16'h0000;
      prev_q     <= 16'h0000;
      cnt_q      <= '0;
      matrix_q   <= 16'h0000;
      key_q      <= 4'd0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      div_q      <= div_d;
      col_q      <= col_d;
      kp_col_q   <= kp_col_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      matrix_q   <= matrix_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign read_data_o         = rdata_q;
  assign interrupt_request_o = irq_q;
  assign kp_col_o            = kp_col_q;

endmodule

// File: doc/keypad_sb_ctrl.md
# keypad_sb_ctrl

System-bus peripheral controller for a 4x4 matrix keypad; the input-side counterpart of the multiplexed seven-segment display controller. Scans the keypad one column at a time, synchronizes and debounces the row returns, and latches each new key press as a 4-bit code. The CPU reads the code over the system bus and receives an interrupt request per press. Sits on the peripheral bus alongside the other `*_sb_ctrl` blocks.

## Interface
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled; must be >= 4
- DEBOUNCE_SCANS, 4, consecutive identical full-matrix frames required to accept a new matrix state; must be >= 1
- clk_i  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr_i  in  32  byte offset within the peripheral
- req_i  in  1  bus request
- write_data_i  in  32  write data
- write_enable_i  in  1  1 = write, 0 = read
- read_data_o  out  32  registered read data
- interrupt_request_o  out  1  key-event interrupt
- interrupt_return_i  in  1  interrupt acknowledge pulse from the interrupt controller
- kp_col_o  out  4  column drive, active-low, exactly one bit low
- kp_row_i  in  4  row return, active-low (external pull-ups), asynchronous

## Operation
- Register map (read = req_i & ~write_enable_i, write = req_i & write_enable_i):
  - 0x00 KEY (RO): [3:0] code of last accepted press, code = row*4 + col. Reading clears STATUS.valid, STATUS.overrun and interrupt_request_o.
  - 0x04 STATUS (RO): [0] valid, [1] overrun.
  - 0x08 MATRIX (RO): [15:0] debounced matrix, bit row*4+col = 1 when pressed.
  - 0x24 RESET (WO): write with data[0]=1 has the same effect as rst.
  - Unmapped reads return 0; writes to RO or unmapped addresses are ignored.
- Row input: kp_row_i passes through a 2-flop synchronizer, then is inverted (pressed = 1).
- Scanner: divider counts 0..SCAN_DIV-1; column index col counts 0..3 and wraps. kp_col_o = ~(4'b0001 << col).
- At divider terminal count: the 4 synchronized row bits are stored into frame bits {row*4+col}, and col advances. Sampling col 3 completes a frame.
- Debounce, on frame completion: if frame == previous frame, stable_cnt increments, saturating at DEBOUNCE_SCANS-1; otherwise stable_cnt = 0. When stable_cnt reaches DEBOUNCE_SCANS-1 (after this frame), matrix <= frame. DEBOUNCE_SCANS = 1 accepts every frame.
- Press event: on a matrix update, rising = new & ~old. If rising != 0: KEY <= lowest set index, valid <= 1, interrupt_request_o <= 1, and overrun <= 1 if valid was already 1. Releases produce no event.
- interrupt_return_i clears interrupt_request_o only; valid and KEY are retained.

## Timing
- Reset values: kp_col_o = 4'b1110, read_data_o = 0, interrupt_request_o = 0, KEY = 0, STATUS = 0, MATRIX = 0, frame = 0, divider = 0, col = 0, stable_cnt = 0.
- Reads: read_data_o updates one cycle after the read request and holds its value between reads.
- Writes: take effect on the next clock edge.
- Frame period is 4*SCAN_DIV cycles; synchronizer latency is 2 cycles, which fits inside SCAN_DIV.
- A press that is stable before a frame start produces valid and interrupt_request_o D frames later, in the cycle after the D-th frame completes (D = DEBOUNCE_SCANS).
- A KEY read and a press event in the same cycle:
  - The event wins: valid = 1 and interrupt_request_o = 1 after the edge, and KEY holds the new code.
  - The read returns the old KEY.
  - overrun is set.
- interrupt_return_i and a press event in the same cycle: the event wins and interrupt_request_o = 1.
- rst or soft reset mid-scan: all state returns to reset values on the next edge, and scanning restarts at col 0.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2, frame = 16 cycles. A keypad model drives kp_row_i[r] low while kp_col_o[c] is low and key (r,c) is held.
- Reset check: assert rst for 2 cycles -> kp_col_o = 4'b1110 and it rotates every 4 cycles (1101, 1011, 0111, 1110); reads of 0x00/0x04/0x08 return 0; interrupt_request_o = 0.
- Single press: hold key row1/col2 -> within 3 frames STATUS = 1, interrupt_request_o = 1, KEY = 6, MATRIX = 0x0040. Then read 0x00 -> returns 6, and STATUS = 0, interrupt_request_o = 0 on the following cycle.
- Bounce rejection: toggle key 5 every frame for 8 frames -> no event, MATRIX stays 0. Then hold it -> exactly one event with KEY = 5.
- Multiple keys and overrun:
  - Press keys 9 and 3 in the same frame -> KEY = 3, MATRIX = 0x0208, STATUS = 1.
  - Without reading, release both, then press key 15 -> KEY = 15, STATUS = 3.
- Acknowledge: interrupt_return_i pulse after an event -> interrupt_request_o = 0, STATUS.valid stays 1, KEY unchanged.
- Soft reset: write 1 to 0x24 mid-frame with a key held -> next cycle all registers are 0 and kp_col_o = 4'b1110. The held key is re-reported after 2 new frames.
